// File: rtl/jtag_tap_param.sv
// Parametrised IEEE 1149.1 TAP: 16-state controller, configurable IR, and a DR mux over
// BYPASS, IDCODE, boundary scan and NUM_USER user registers.
module jtag_tap_param #(
  parameter int          IR_WIDTH   = 4,
  parameter int          BSR_LEN    = 10,
  parameter int          NUM_USER   = 2,
  parameter int          USER_WIDTH = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5A5B,
  parameter int          OP_SAMPLE  = 1,
  parameter int          OP_EXTEST  = 2,
  parameter int          OP_INTEST  = 3,
  parameter int          OP_IDCODE  = 7,
  parameter int          OP_USER0   = 8
) (
  input  logic                             TCK,
  input  logic                             TRST_N,
  input  logic                             TMS,
  input  logic                             TDI,
  output logic                             TDO,
  output logic                             TDO_EN,
  output logic [3:0]                       state,
  output logic [IR_WIDTH-1:0]              ir_out,
  output logic                             sample_sel,
  output logic                             extest_sel,
  output logic                             intest_sel,
  output logic                             idcode_sel,
  output logic                             bypass_sel,
  output logic [NUM_USER-1:0]              user_sel,
  input  logic [BSR_LEN-1:0]               BSR_PI,
  output logic [BSR_LEN-1:0]               BSR_PO,
  input  logic [NUM_USER*USER_WIDTH-1:0]   USER_PI,
  output logic [NUM_USER*USER_WIDTH-1:0]   USER_PO,
  output logic [NUM_USER-1:0]              user_upd
);

  localparam logic [3:0] TLR   = 4'hF;
  localparam logic [3:0] RTI   = 4'hC;
  localparam logic [3:0] SELDR = 4'h7;
  localparam logic [3:0] CAPDR = 4'h6;
  localparam logic [3:0] SHDR  = 4'h2;
  localparam logic [3:0] EX1DR = 4'h1;
  localparam logic [3:0] PDR   = 4'h3;
  localparam logic [3:0] EX2DR = 4'h0;
  localparam logic [3:0] UPDR  = 4'h5;
  localparam logic [3:0] SELIR = 4'h4;
  localparam logic [3:0] CAPIR = 4'hE;
  localparam logic [3:0] SHIR  = 4'hA;
  localparam logic [3:0] EX1IR = 4'h9;
  localparam logic [3:0] PIR   = 4'hB;
  localparam logic [3:0] EX2IR = 4'h8;
  localparam logic [3:0] UPIR  = 4'hD;

  localparam int UW = USER_WIDTH;
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE = IR_WIDTH'(OP_SAMPLE);
  localparam logic [IR_WIDTH-1:0] IR_EXTEST = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_INTEST = IR_WIDTH'(OP_INTEST);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(OP_IDCODE);

  logic [3:0]                   state_n;
  logic [IR_WIDTH-1:0]          ir_sr, ir_sr_n;
  logic [31:0]                  idc_sr, idc_n;
  logic                         byp_sr, byp_n;
  logic [BSR_LEN-1:0]           bsr_sr, bsr_n;
  logic [NUM_USER*UW-1:0]       user_sr, user_n;
  logic [NUM_USER-1:0]          user_bit0;
  logic                         tdo_n;
  logic                         bsr_sel;
  logic                         fixed_hit;

  always_comb begin
    state_n = TLR;
    case (state)
      TLR:     state_n = TMS ? TLR   : RTI;
      RTI:     state_n = TMS ? SELDR : RTI;
      SELDR:   state_n = TMS ? SELIR : CAPDR;
      CAPDR:   state_n = TMS ? EX1DR : SHDR;
      SHDR:    state_n = TMS ? EX1DR : SHDR;
      EX1DR:   state_n = TMS ? UPDR  : PDR;
      PDR:     state_n = TMS ? EX2DR : PDR;
      EX2DR:   state_n = TMS ? UPDR  : SHDR;
      UPDR:    state_n = TMS ? SELDR : RTI;
      SELIR:   state_n = TMS ? TLR   : CAPIR;
      CAPIR:   state_n = TMS ? EX1IR : SHIR;
      SHIR:    state_n = TMS ? EX1IR : SHIR;
      EX1IR:   state_n = TMS ? UPIR  : PIR;
      PIR:     state_n = TMS ? EX2IR : PIR;
      EX2IR:   state_n = TMS ? UPIR  : SHIR;
      UPIR:    state_n = TMS ? SELDR : RTI;
      default: state_n = TLR;
    endcase
  end

  // Fixed opcodes take priority over user opcodes; anything unrecognised falls to bypass.
  always_comb begin
    sample_sel = (ir_out == IR_SAMPLE);
    extest_sel = (ir_out == IR_EXTEST) && !sample_sel;
    intest_sel = (ir_out == IR_INTEST) && !sample_sel && !extest_sel;
    idcode_sel = (ir_out == IR_IDCODE) && !sample_sel && !extest_sel && !intest_sel;
    fixed_hit  = sample_sel | extest_sel | intest_sel | idcode_sel;
    user_sel   = '0;
    for (int k = 0; k < NUM_USER; k++) begin
      if (!fixed_hit && (ir_out == IR_WIDTH'(OP_USER0 + k))) user_sel[k] = 1'b1;
    end
    bypass_sel = !fixed_hit && (user_sel == '0);
    bsr_sel    = sample_sel | extest_sel | intest_sel;
  end

  always_comb begin
    ir_sr_n   = ir_sr;
    idc_n     = idc_sr;
    byp_n     = byp_sr;
    bsr_n     = bsr_sr;
    user_n    = user_sr;
    tdo_n     = TDO;
    user_bit0 = '0;
    case (state)
      CAPIR: ir_sr_n = IR_WIDTH'(1);
      SHIR:  ir_sr_n = {TDI, ir_sr[IR_WIDTH-1:1]};
      CAPDR: begin
        if (idcode_sel) idc_n = IDCODE_VAL;
        if (bypass_sel) byp_n = 1'b0;
        if (bsr_sel)    bsr_n = BSR_PI;
        for (int k = 0; k < NUM_USER; k++) begin
          if (user_sel[k]) user_n[k*UW +: UW] = USER_PI[k*UW +: UW];
        end
      end
      SHDR: begin
        if (idcode_sel) idc_n = {TDI, idc_sr[31:1]};
        if (bypass_sel) byp_n = TDI;
        if (bsr_sel)    bsr_n = {TDI, bsr_sr[BSR_LEN-1:1]};
        for (int k = 0; k < NUM_USER; k++) begin
          if (user_sel[k]) user_n[k*UW +: UW] = {TDI, user_sr[k*UW+1 +: UW-1]};
        end
      end
      default: ;
    endcase
    for (int k = 0; k < NUM_USER; k++) user_bit0[k] = user_n[k*UW];
    // TDO follows bit0 of the register as it stands after this edge.
    if (state == CAPIR || state == SHIR) begin
      tdo_n = ir_sr_n[0];
    end else if (state == CAPDR || state == SHDR) begin
      tdo_n = (idcode_sel & idc_n[0]) | (bypass_sel & byp_n) |
              (bsr_sel & bsr_n[0]) | (|(user_sel & user_bit0));
    end
  end

  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      state    <= TLR;
      ir_out   <= IR_IDCODE;
      ir_sr    <= '0;
      idc_sr   <= '0;
      byp_sr   <= 1'b0;
      bsr_sr   <= '0;
      user_sr  <= '0;
      BSR_PO   <= '0;
      USER_PO  <= '0;
      user_upd <= '0;
      TDO      <= 1'b0;
    end else begin
      state    <= state_n;
      ir_sr    <= ir_sr_n;
      idc_sr   <= idc_n;
      byp_sr   <= byp_n;
      bsr_sr   <= bsr_n;
      user_sr  <= user_n;
      TDO      <= tdo_n;
      user_upd <= '0;
      if (state == TLR)       ir_out <= IR_IDCODE;
      else if (state == UPIR) ir_out <= ir_sr;
      if (state == UPDR) begin
        if (bsr_sel) BSR_PO <= bsr_sr;
        for (int k = 0; k < NUM_USER; k++) begin
          if (user_sel[k]) begin
            USER_PO[k*UW +: UW] <= user_sr[k*UW +: UW];
            user_upd[k]         <= 1'b1;
          end
        end
      end
    end
  end

  assign TDO_EN = (state == SHDR) || (state == SHIR);

endmodule

// File: tb/tb_jtag_tap_param.sv
// Bench for jtag_tap_param: directed scans with literal expectations plus randomized
// TAP traffic, all compared each cycle against a behavioural TAP model.
module tb_jtag_tap_param;

  localparam int          IR_WIDTH   = 4;
  localparam int          BSR_LEN    = 10;
  localparam int          NUM_USER   = 2;
  localparam int          USER_WIDTH = 8;
  localparam int          UW_ALL     = NUM_USER * USER_WIDTH;
  localparam logic [31:0] IDCODE_VAL = 32'h1234_5A5B;
  localparam int          OP_SAMPLE  = 1;
  localparam int          OP_EXTEST  = 2;
  localparam int          OP_INTEST  = 3;
  localparam int          OP_IDCODE  = 7;
  localparam int          OP_USER0   = 8;

  localparam int S_TLR = 15, S_CAPDR = 6, S_SHDR = 2, S_UPDR = 5;
  localparam int S_CAPIR = 14, S_SHIR = 10, S_UPIR = 13;

  logic                  TCK = 1'b0;
  logic                  TRST_N, TMS, TDI, TDO, TDO_EN;
  logic [3:0]            state;
  logic [IR_WIDTH-1:0]   ir_out;
  logic                  sample_sel, extest_sel, intest_sel, idcode_sel, bypass_sel;
  logic [NUM_USER-1:0]   user_sel, user_upd;
  logic [BSR_LEN-1:0]    BSR_PI, BSR_PO;
  logic [UW_ALL-1:0]     USER_PI, USER_PO;

  jtag_tap_param #(
    .IR_WIDTH(IR_WIDTH), .BSR_LEN(BSR_LEN), .NUM_USER(NUM_USER), .USER_WIDTH(USER_WIDTH),
    .IDCODE_VAL(IDCODE_VAL), .OP_SAMPLE(OP_SAMPLE), .OP_EXTEST(OP_EXTEST),
    .OP_INTEST(OP_INTEST), .OP_IDCODE(OP_IDCODE), .OP_USER0(OP_USER0)
  ) dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .state(state), .ir_out(ir_out), .sample_sel(sample_sel), .extest_sel(extest_sel),
    .intest_sel(intest_sel), .idcode_sel(idcode_sel), .bypass_sel(bypass_sel),
    .user_sel(user_sel), .BSR_PI(BSR_PI), .BSR_PO(BSR_PO), .USER_PI(USER_PI),
    .USER_PO(USER_PO), .user_upd(user_upd)
  );

  always #5 TCK = ~TCK;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit check_en  = 1'b0;

  // TAP diagram as next-state tables indexed by state encoding.
  int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

  int                   m_state;
  logic [IR_WIDTH-1:0]  m_ir, m_irsr;
  logic [63:0]          m_dr [NUM_USER+3];
  int                   m_len [NUM_USER+3];
  logic [BSR_LEN-1:0]   m_bsr_po;
  logic [UW_ALL-1:0]    m_user_po;
  logic [NUM_USER-1:0]  m_upd;
  logic                 m_tdo;
  int                   c_d;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Register index the instruction routes between TDI and TDO: 0 bypass, 1 idcode, 2 bsr, 3+k user k.
  function automatic int dr_of(input logic [IR_WIDTH-1:0] ir);
    int v;
    v = int'(ir);
    if (v == OP_SAMPLE || v == OP_EXTEST || v == OP_INTEST) return 2;
    if (v == OP_IDCODE) return 1;
    if (v >= OP_USER0 && v < OP_USER0 + NUM_USER) return 3 + v - OP_USER0;
    return 0;
  endfunction

  task automatic model_step();
    int d;
    if (!TRST_N) begin
      m_state   = S_TLR;
      m_ir      = IR_WIDTH'(OP_IDCODE);
      m_irsr    = '0;
      for (int i = 0; i < NUM_USER + 3; i++) m_dr[i] = '0;
      m_bsr_po  = '0;
      m_user_po = '0;
      m_upd     = '0;
      m_tdo     = 1'b0;
    end else begin
      d     = dr_of(m_ir);
      m_upd = '0;
      case (m_state)
        S_TLR:   m_ir = IR_WIDTH'(OP_IDCODE);
        S_CAPIR: begin m_irsr = IR_WIDTH'(1); m_tdo = 1'b1; end
        S_SHIR:  begin
          m_irsr = (m_irsr >> 1) | (IR_WIDTH'(TDI) << (IR_WIDTH - 1));
          m_tdo  = m_irsr[0];
        end
        S_UPIR:  m_ir = m_irsr;
        S_CAPDR: begin
          case (d)
            0:       m_dr[0] = '0;
            1:       m_dr[1] = 64'(IDCODE_VAL);
            2:       m_dr[2] = 64'(BSR_PI);
            default: m_dr[d] = 64'(USER_PI[(d-3)*USER_WIDTH +: USER_WIDTH]);
          endcase
          m_tdo = m_dr[d][0];
        end
        S_SHDR:  begin
          m_dr[d] = (m_dr[d] >> 1) | ({63'b0, TDI} << (m_len[d] - 1));
          m_tdo   = m_dr[d][0];
        end
        S_UPDR:  begin
          if (d == 2) m_bsr_po = m_dr[2][BSR_LEN-1:0];
          else if (d >= 3) begin
            m_user_po[(d-3)*USER_WIDTH +: USER_WIDTH] = m_dr[d][USER_WIDTH-1:0];
            m_upd[d-3] = 1'b1;
          end
        end
        default: ;
      endcase
      m_state = TMS ? nxt1[m_state] : nxt0[m_state];
    end
  endtask

  always @(negedge TCK) begin
    if (check_en) begin
      c_d = dr_of(m_ir);
      checkOutput("state",    64'(state),  64'(m_state));
      checkOutput("ir_out",   64'(ir_out), 64'(m_ir));
      checkOutput("TDO",      64'(TDO),    64'(m_tdo));
      checkOutput("TDO_EN",   64'(TDO_EN), 64'(m_state == S_SHDR || m_state == S_SHIR));
      checkOutput("selects",  64'({sample_sel, extest_sel, intest_sel, idcode_sel, bypass_sel}),
                  64'({int'(m_ir) == OP_SAMPLE, int'(m_ir) == OP_EXTEST,
                       int'(m_ir) == OP_INTEST, int'(m_ir) == OP_IDCODE, c_d == 0}));
      checkOutput("user_sel", 64'(user_sel), (c_d >= 3) ? (64'd1 << (c_d - 3)) : 64'd0);
      checkOutput("BSR_PO",   64'(BSR_PO),   64'(m_bsr_po));
      checkOutput("USER_PO",  64'(USER_PO),  64'(m_user_po));
      checkOutput("user_upd", 64'(user_upd), 64'(m_upd));
    end
  end

  // Inputs change just after the falling edge; the task returns just after the rising edge.
  task automatic applyStimulus(input logic tms, input logic tdi);
    @(negedge TCK);
    #1;
    TRST_N = 1'b1;
    TMS    = tms;
    TDI    = tdi;
    model_step();
    @(posedge TCK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge TCK);
    #1;
    TRST_N = 1'b0;
    TMS    = 1'($urandom);
    TDI    = 1'($urandom);
    model_step();
    @(posedge TCK);
    #1;
  endtask

  task automatic go_rti();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'($urandom));
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [IR_WIDTH-1:0] val, output logic [IR_WIDTH-1:0] cap);
    cap = '0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    cap[0] = TDO;
    for (int i = 0; i < IR_WIDTH; i++) begin
      applyStimulus(i == IR_WIDTH - 1, val[i]);
      if (i + 1 < IR_WIDTH) cap[i+1] = TDO;
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  // rst_at = n > 0 replaces shift edge n with a reset edge and abandons the scan.
  task automatic scan_dr(input int len, input logic [63:0] tdi, input int rst_at,
                         output logic [63:0] out);
    out = '0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    out[0] = TDO;
    for (int i = 0; i < len; i++) begin
      if (rst_at == i + 1) begin
        do_reset();
        return;
      end
      applyStimulus(i == len - 1, tdi[i]);
      if (i + 1 < len) out[i+1] = TDO;
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  logic [IR_WIDTH-1:0] cap;
  logic [63:0]         sout;
  int                  r, len;

  initial begin
    TRST_N  = 1'b0;
    TMS     = 1'b1;
    TDI     = 1'b0;
    BSR_PI  = '0;
    USER_PI = '0;
    m_len[0] = 1;
    m_len[1] = 32;
    m_len[2] = BSR_LEN;
    for (int k = 0; k < NUM_USER; k++) m_len[3+k] = USER_WIDTH;

    do_reset();
    check_en = 1'b1;
    checkOutput("rst_state",   64'(state),    64'hF);
    checkOutput("rst_ir",      64'(ir_out),   64'd7);
    checkOutput("rst_tdo",     64'(TDO),      64'd0);
    checkOutput("rst_bsr_po",  64'(BSR_PO),   64'd0);
    checkOutput("rst_user_po", 64'(USER_PO),  64'd0);
    checkOutput("rst_upd",     64'(user_upd), 64'd0);

    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("tms5_state",  64'(state),  64'hF);
    checkOutput("tms5_ir",     64'(ir_out), 64'd7);
    checkOutput("tms5_bsr_po", 64'(BSR_PO), 64'd0);

    applyStimulus(1'b0, 1'b0);
    scan_dr(32, 64'd0, 0, sout);
    checkOutput("idcode_stream", sout, 64'h1234_5A5B);

    load_ir(4'hF, cap);
    checkOutput("capir_pattern", 64'(cap), 64'b0001);
    checkOutput("bypass_sel", 64'(bypass_sel), 64'd1);
    scan_dr(5, 64'b01101, 0, sout);
    checkOutput("bypass_echo", sout, 64'b11010);

    load_ir(4'd9, cap);
    scan_dr(8, 64'hA5, 0, sout);
    checkOutput("user1_po",  64'(USER_PO[15:8]), 64'hA5);
    checkOutput("user0_po",  64'(USER_PO[7:0]),  64'h00);
    checkOutput("user1_upd", 64'(user_upd),      64'b10);
    applyStimulus(1'b0, 1'b0);
    checkOutput("user_upd_clear", 64'(user_upd), 64'b00);

    load_ir(4'd2, cap);
    BSR_PI = 10'h2AA;
    scan_dr(10, 64'd0, 0, sout);
    checkOutput("extest_stream", sout, 64'h2AA);
    checkOutput("extest_bsr_po", 64'(BSR_PO), 64'd0);

    scan_dr(10, 64'h3FF, 5, sout);
    checkOutput("midrst_state",  64'(state),  64'hF);
    checkOutput("midrst_bsr_po", 64'(BSR_PO), 64'd0);

    for (int it = 0; it < 60; it++) begin
      go_rti();
      r = $urandom_range(0, 3);
      BSR_PI  = BSR_LEN'($urandom);
      USER_PI = UW_ALL'($urandom);
      case (r)
        0: load_ir(IR_WIDTH'($urandom), cap);
        1: begin
          len = $urandom_range(1, 40);
          scan_dr(len, {$urandom, $urandom}, 0, sout);
        end
        2: begin
          len = $urandom_range(1, 40);
          scan_dr(len, {$urandom, $urandom}, $urandom_range(1, len), sout);
        end
        default: begin
          for (int c = 0; c < 30; c++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else applyStimulus(($urandom_range(0, 9) < 4), 1'($urandom));
          end
        end
      endcase
    end

    @(negedge TCK);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/jtag_tap_param.md
Name: jtag_tap_param

Overview:
- Parametrised second-generation JTAG TAP: full 16-state IEEE 1149.1 controller, IR of configurable width, and a DR mux over BYPASS, IDCODE, boundary-scan register (BSR) and NUM_USER user data registers.
- Replaces the fixed 4-bit-IR TAP/IR/DR/bypass cluster in the FPGA test top.
- Exports decoded instruction selects, BSR update latches and per-user update strobes to core logic, BIST and LED/GPIO muxing.

Parameters:
- IR_WIDTH, 4, instruction register width (>=2)
- BSR_LEN, 10, boundary-scan cells
- NUM_USER, 2, user data registers (1..8)
- USER_WIDTH, 8, bits per user register
- IDCODE_VAL, 32'h1234_5A5B, IDCODE contents (bit0 must be 1)
- OP_SAMPLE, 1, SAMPLE/PRELOAD opcode
- OP_EXTEST, 2, EXTEST opcode
- OP_INTEST, 3, INTEST opcode
- OP_IDCODE, 7, IDCODE opcode
- OP_USER0, 8, opcode of USER0; USERk = OP_USER0+k

Ports:
- TCK  in  1  sole clock, all logic on posedge
- TRST_N  in  1  synchronous active-low reset
- TMS  in  1  mode select
- TDI  in  1  serial data in
- TDO  out  1  registered serial data out
- TDO_EN  out  1  high while state is SHDR or SHIR
- state  out  4  current TAP state (encoding below)
- ir_out  out  IR_WIDTH  latched instruction
- sample_sel/extest_sel/intest_sel/idcode_sel/bypass_sel  out  1 each  decoded from ir_out
- user_sel  out  NUM_USER  one-hot USERk select
- BSR_PI  in  BSR_LEN  parallel capture value for BSR
- BSR_PO  out  BSR_LEN  BSR update latch
- USER_PI  in  NUM_USER*USER_WIDTH  capture values, user k at [k*USER_WIDTH +: USER_WIDTH]
- USER_PO  out  NUM_USER*USER_WIDTH  user update latches
- user_upd  out  NUM_USER  one-cycle update strobe per user register

Behaviour:
- State encoding:
  - TLR=F, RTI=C, SELDR=7, CAPDR=6, SHDR=2, EX1DR=1, PDR=3, EX2DR=0, UPDR=5
  - SELIR=4, CAPIR=E, SHIR=A, EX1IR=9, PIR=B, EX2IR=8, UPIR=D
- Transitions per IEEE 1149.1 on posedge TCK by TMS. Five consecutive TMS=1 edges reach TLR from any state.
- Reset (TRST_N=0 at posedge): state=TLR, ir_out=OP_IDCODE, shift registers=0, BSR_PO=0, USER_PO=0, user_upd=0, TDO=0.
- While state==TLR: ir_out forced to OP_IDCODE every edge; BSR_PO and USER_PO hold.
- Actions occur on the posedge taken while in the named state:
  - CAPIR: IR shift reg <= {0..0,01}.
  - SHIR: IR shift reg <= {TDI, sr[IR_WIDTH-1:1]}.
  - UPIR: ir_out <= IR shift reg.
  - CAPDR: selected DR loads its capture value:
    - IDCODE_VAL
    - BYPASS: 0
    - BSR: BSR_PI
    - USERk: USER_PI slice k
  - SHDR: selected DR shifts right, TDI into MSB. Unselected DRs hold.
  - UPDR:
    - SAMPLE/EXTEST/INTEST: BSR_PO <= BSR shift reg.
    - USERk: USER_PO slice k <= shift reg, and user_upd[k]=1 for exactly that cycle.
    - IDCODE/BYPASS: no latch.
- Pause and Exit states hold all registers.
- TDO: on every CAPxx/SHxx edge, TDO <= bit0 of the post-edge value of the active shift register (IR in the IR column, selected DR in the DR column). Otherwise TDO holds.
  - Net effect: after a capture edge TDO shows bit0; after shift edge n it shows bit n.
- Decode:
  - ir_out equal to an opcode asserts the matching select.
  - Opcodes OP_USER0..OP_USER0+NUM_USER-1 assert user_sel.
  - All other values, including all-ones, assert bypass_sel (exactly one select high at all times).
  - If a user opcode collides with a fixed opcode, the fixed opcode wins.
- BYPASS is one bit, so a TDI->TDO path through it delays the stream by one shift edge.
- Reset asserted mid-shift: the next edge is the reset, with no partial update.

Test Plan:
- TRST_N=0 one edge, then 5 TMS=1 edges from SHDR -> state=F, ir_out=7, TDO=0, BSR_PO=0.
- From RTI, TMS 1,0,0 to CAPDR then 31 SHDR edges, TDI=0 -> TDO sequence = IDCODE_VAL bits 0..31 (0x1234_5A5B LSB first).
- Load IR=4'hF via SHIR (4 edges, TDI=1) then UPIR -> bypass_sel=1. Shift TDI pattern 1011 in SHDR -> TDO echoes it one edge late.
- CAPIR then shift 4 edges -> TDO shows 1,0,0,0, confirming the capture pattern.
- IR=9 (USER1), shift 0xA5 LSB first, UPDR -> USER_PO[15:8]=0xA5, user_upd=2'b10 for one cycle, USER_PO[7:0] unchanged.
- IR=2 (EXTEST), BSR_PI=10'h2AA, CAPDR, shift 10 zeros, UPDR -> TDO stream=0x2AA LSB first, BSR_PO=0.
- Repeat with TRST_N dropped on the 5th shift edge -> BSR_PO stays 0.
